fib_stack: RTL and testbench

- LIFO operand stack for the Fibonacci datapath.
- It is the responder to the Fibonacci controller's push/pop/clr strobes and returns top-of-stack data plus the empty/full status that the controller branches on.
- It holds pending n values during the recursive evaluation.
- It is single-cycle per operation, with no stalls and no ready signal.

---
 rtl/fib_pkg.sv | 19 +
 rtl/fib_stack_mem.sv | 32 +++
 rtl/fib_stack.sv | 166 ++++++++++++++++
 tb/tb_fib_stack.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci datapath: default sizes and the
// stack operation encoding formed from the controller's {push,pop} strobes.
package fib_pkg;

  localparam int FIB_DW    = 16;
  localparam int FIB_DEPTH = 16;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_REPL = 2'b11
  } stack_op_e;

  function automatic stack_op_e decode_op(input logic push, input logic pop);
    return stack_op_e'({push, pop});
  endfunction

endpackage

// File: rtl/fib_stack_mem.sv
// Stack register file: one synchronous write port and two combinational
// read ports (top-of-stack and the entry beneath it). Contents are not reset.
module fib_stack_mem
  import fib_pkg::*;
#(
  parameter int  DW    = FIB_DW,
  parameter int  DEPTH = FIB_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_top,
  output logic [DW-1:0] rdata_top,
  input  logic [AW-1:0] raddr_sub,
  output logic [DW-1:0] rdata_sub
);

  logic [DW-1:0] mem_r [DEPTH];

  // Single write port; storage is deliberately left without reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata_top = mem_r[raddr_top];
  assign rdata_sub = mem_r[raddr_sub];

endmodule

// File: rtl/fib_stack.sv
// LIFO operand stack for the Fibonacci controller with registered top-of-stack.
// Optional high-water-mark output enabled by defining FIB_STACK_PEAK_EN.
module fib_stack
  import fib_pkg::*;
#(
  parameter int  DW    = FIB_DW,
  parameter int  DEPTH = FIB_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          CLR,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          ovf,
  output logic          udf
`ifdef FIB_STACK_PEAK_EN
  ,
  output logic [AW:0]   peak
`endif
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ZERO_CNT = (AW + 1)'(0);
  localparam logic [AW:0] ONE_CNT  = (AW + 1)'(1);

  logic [AW:0]   count_r, count_s;
  logic [DW-1:0] dout_r, dout_s;
  logic          ovf_r, ovf_s;
  logic          udf_r, udf_s;
  logic          we_s;
  logic [AW-1:0] waddr_s;
  logic [AW-1:0] top_addr_s, sub_addr_s;
  logic [DW-1:0] rd_top_s, rd_sub_s;
  logic          empty_s, full_s;
  stack_op_e     op_s;

  assign empty_s    = (count_r == ZERO_CNT);
  assign full_s     = (count_r == FULL_CNT);
  assign top_addr_s = count_r[AW-1:0] - AW'(1);
  assign sub_addr_s = count_r[AW-1:0] - AW'(2);
  assign op_s       = decode_op(push, pop);

  fib_stack_mem #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk       (clk),
    .we        (we_s),
    .waddr     (waddr_s),
    .wdata     (din),
    .raddr_top (top_addr_s),
    .rdata_top (rd_top_s),
    .raddr_sub (sub_addr_s),
    .rdata_sub (rd_sub_s)
  );

  // Next-state for pointer, top-of-stack view, sticky flags and write strobe.
  always_comb begin
    count_s = count_r;
    dout_s  = empty_s ? {DW{1'b0}} : rd_top_s;
    ovf_s   = ovf_r;
    udf_s   = udf_r;
    we_s    = 1'b0;
    waddr_s = count_r[AW-1:0];
    if (clr) begin
      count_s = ZERO_CNT;
      dout_s  = {DW{1'b0}};
      ovf_s   = 1'b0;
      udf_s   = 1'b0;
    end else begin
      case (op_s)
        OP_PUSH: begin
          if (full_s) begin
            ovf_s = 1'b1;
          end else begin
            we_s    = 1'b1;
            count_s = count_r + ONE_CNT;
            dout_s  = din;
          end
        end
        OP_REPL: begin
          // Replace-top ignores full; on an empty stack it degrades to a push.
          we_s   = 1'b1;
          dout_s = din;
          if (empty_s) begin
            count_s = count_r + ONE_CNT;
          end else begin
            waddr_s = top_addr_s;
          end
        end
        OP_POP: begin
          if (empty_s) begin
            udf_s = 1'b1;
          end else if (count_r == ONE_CNT) begin
            count_s = ZERO_CNT;
            dout_s  = {DW{1'b0}};
          end else begin
            count_s = count_r - ONE_CNT;
            dout_s  = rd_sub_s;
          end
        end
        OP_IDLE: begin
          count_s = count_r;
        end
        default: begin
          count_s = count_r;
        end
      endcase
    end
  end

  // State registers; CLR discards any in-flight operation.
  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      count_r <= ZERO_CNT;
      dout_r  <= {DW{1'b0}};
      ovf_r   <= 1'b0;
      udf_r   <= 1'b0;
    end else begin
      count_r <= count_s;
      dout_r  <= dout_s;
      ovf_r   <= ovf_s;
      udf_r   <= udf_s;
    end
  end

  assign dout  = dout_r;
  assign count = count_r;
  assign empty = empty_s;
  assign full  = full_s;
  assign ovf   = ovf_r;
  assign udf   = udf_r;

`ifdef FIB_STACK_PEAK_EN
  logic [AW:0] peak_r, peak_s;

  // High-water mark tracks the occupancy that count is about to take.
  always_comb begin
    if (clr) begin
      peak_s = ZERO_CNT;
    end else if (count_s > peak_r) begin
      peak_s = count_s;
    end else begin
      peak_s = peak_r;
    end
  end

  // Peak register shares the stack's reset behaviour.
  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      peak_r <= ZERO_CNT;
    end else begin
      peak_r <= peak_s;
    end
  end

  assign peak = peak_r;
`endif

endmodule

// File: tb/tb_fib_stack.sv
// Directed bench for fib_stack: a queue-based reference stack predicts each
// cycle's outputs, which are queued and compared after the active edge.
module tb_fib_stack;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        CLR, clr, push, pop;
  logic [15:0] din, dout;
  logic        empty, full, ovf, udf;
  logic [4:0]  count;
`ifdef FIB_STACK_PEAK_EN
  logic [4:0]  peak;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    int count;
    int dout;
    int empty;
    int full;
    int ovf;
    int udf;
    int peak;
  } exp_t;

  exp_t exp_q[$];
  int   m_stk[$];
  int   m_dout, m_ovf, m_udf, m_peak;

  always #5 clk = ~clk;

  fib_stack dut (
    .clk   (clk),
    .CLR   (CLR),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .empty (empty),
    .full  (full),
    .count (count),
    .ovf   (ovf),
    .udf   (udf)
`ifdef FIB_STACK_PEAK_EN
    ,
    .peak  (peak)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_stk.delete();
    m_dout = 0;
    m_ovf  = 0;
    m_udf  = 0;
    m_peak = 0;
  endtask

  task automatic model_op(input logic c, input logic p, input logic q, input int d);
    if (c) begin
      model_reset();
    end else if (p && q && m_stk.size() > 0) begin
      m_stk[m_stk.size() - 1] = d;
      m_dout = d;
    end else if (p) begin
      if (m_stk.size() < DEPTH) begin
        m_stk.push_back(d);
        m_dout = d;
      end else begin
        m_ovf = 1;
      end
    end else if (q) begin
      if (m_stk.size() > 0) begin
        void'(m_stk.pop_back());
        m_dout = (m_stk.size() > 0) ? m_stk[m_stk.size() - 1] : 0;
      end else begin
        m_udf = 1;
      end
    end
    if (m_stk.size() > m_peak) m_peak = m_stk.size();
  endtask

  function automatic exp_t snap();
    exp_t e;
    e.count = m_stk.size();
    e.dout  = m_dout;
    e.empty = (m_stk.size() == 0) ? 1 : 0;
    e.full  = (m_stk.size() == DEPTH) ? 1 : 0;
    e.ovf   = m_ovf;
    e.udf   = m_udf;
    e.peak  = m_peak;
    return e;
  endfunction

  task automatic step(input string tag, input logic c, input logic p, input logic q, input logic [15:0] d);
    exp_t e;
    clr  = c;
    push = p;
    pop  = q;
    din  = d;
    model_op(c, p, q, int'(d));
    exp_q.push_back(snap());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, ".count"}, 32'(count), e.count);
    chk({tag, ".dout"},  32'(dout),  e.dout);
    chk({tag, ".empty"}, 32'(empty), e.empty);
    chk({tag, ".full"},  32'(full),  e.full);
    chk({tag, ".ovf"},   32'(ovf),   e.ovf);
    chk({tag, ".udf"},   32'(udf),   e.udf);
`ifdef FIB_STACK_PEAK_EN
    chk({tag, ".peak"},  32'(peak),  e.peak);
`endif
    clr  = 1'b0;
    push = 1'b0;
    pop  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    CLR  = 1'b0;
    clr  = 1'b0;
    push = 1'b1;
    pop  = 1'b0;
    din  = 16'h0005;
    model_reset();

    // Reset held across several edges with a push pending.
    repeat (3) begin
      @(negedge clk);
      chk("rst.count", 32'(count), 0);
      chk("rst.empty", 32'(empty), 1);
      chk("rst.dout",  32'(dout),  0);
    end
    chk("rst.full", 32'(full), 0);
    chk("rst.ovf",  32'(ovf),  0);
    chk("rst.udf",  32'(udf),  0);
    CLR = 1'b1;
    step("first_push", 1'b0, 1'b1, 1'b0, 16'h0005);
    step("clr1", 1'b1, 1'b0, 1'b0, 16'h0000);

    // Basic LIFO ordering.
    step("push3", 1'b0, 1'b1, 1'b0, 16'd3);
    step("push5", 1'b0, 1'b1, 1'b0, 16'd5);
    step("push8", 1'b0, 1'b1, 1'b0, 16'd8);
    step("pop_a", 1'b0, 1'b0, 1'b1, 16'h0000);
    step("pop_b", 1'b0, 1'b0, 1'b1, 16'h0000);
    step("pop_c", 1'b0, 1'b0, 1'b1, 16'h0000);

    // Fill to capacity, overflow, then replace-top while full.
    for (int i = 1; i <= DEPTH; i++) step("fill", 1'b0, 1'b1, 1'b0, 16'(i));
    step("ovf_push", 1'b0, 1'b1, 1'b0, 16'h00FF);
    step("repl_full", 1'b0, 1'b1, 1'b1, 16'h0AAA);
    step("pop_full", 1'b0, 1'b0, 1'b1, 16'h0000);
    step("push_after_pop", 1'b0, 1'b1, 1'b0, 16'h1234);

    // Underflow, replace on empty, clear with a push pending.
    step("clr2", 1'b1, 1'b0, 1'b0, 16'h0000);
    step("udf_pop", 1'b0, 1'b0, 1'b1, 16'h0000);
    step("repl_empty", 1'b0, 1'b1, 1'b1, 16'h0007);
    step("clr_push", 1'b1, 1'b1, 1'b0, 16'h0033);

    // Asynchronous reset between edges with four entries held.
    for (int i = 0; i < 4; i++) step("pre_async", 1'b0, 1'b1, 1'b0, 16'(16'h0010 + i));
    #2;
    CLR = 1'b0;
    #1;
    chk("async.count", 32'(count), 0);
    chk("async.dout",  32'(dout),  0);
    chk("async.empty", 32'(empty), 1);
    chk("async.ovf",   32'(ovf),   0);
    model_reset();
    #1;
    CLR = 1'b1;
    step("post_async_pop", 1'b0, 1'b0, 1'b1, 16'h0000);

    // Occupancy excursion for the high-water mark.
    step("clr3", 1'b1, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 6; i++) step("pk_push", 1'b0, 1'b1, 1'b0, 16'(16'h0100 + i));
    for (int i = 0; i < 4; i++) step("pk_pop", 1'b0, 1'b0, 1'b1, 16'h0000);
    for (int i = 0; i < 2; i++) step("pk_push2", 1'b0, 1'b1, 1'b0, 16'(16'h0200 + i));
    step("clr4", 1'b1, 1'b0, 1'b0, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
